// File: rtl/m92_video_mixer.sv
// m92_video_mixer
// Chooses between a tilemap pixel and a sprite pixel, looks the chosen colour
// up in a 2048x16 palette RAM, and produces 8-bit RGB. The video timing
// signals are delayed by the same amount so they stay aligned with the RGB.
// The CPU reaches the palette RAM through a small access FSM. That FSM only
// uses the RAM on clocks where ce_pix is low, so the pixel pipeline is never
// stalled.
//
// Ports
//   clk, reset          system clock; synchronous active-high reset
//   ce_pix              pixel clock enable
//   tile_color/prio     tilemap colour index and priority-over-sprite flag
//   obj_color           sprite colour index
//   *_in                raw hblank/vblank/hsync/vsync
//   cpu_cs/rd/wr        palette access strobes (rd and wr together = write)
//   cpu_addr, cpu_din   palette word address and data {x,B5,G5,R5}
//   cpu_dout            palette read data
//   busy                CPU access in progress
//   red/green/blue      pixel colour, 3 ce_pix edges after input
//   hblank..vsync       timing delayed to match RGB
module m92_video_mixer #(
  parameter int BLANK_BLACK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [10:0] tile_color,
  input  logic        tile_prio,
  input  logic [10:0] obj_color,
  input  logic        hblank_in,
  input  logic        vblank_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cpu_cs,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [10:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        busy,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hblank,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [10:0] cpu_addr_q;
  logic [15:0] cpu_data_q;
  logic        cpu_wr_q;
  logic [15:0] cpu_q;

  logic [15:0] pal [0:2047];
  logic [10:0] ram_addr;
  logic        ram_we;

  logic [10:0] sel_idx;
  logic [10:0] s1_idx;
  logic [14:0] pix_q;
  logic [2:0]  hb_d, vb_d, hs_d, vs_d;
  logic        blank_s3;

  // Pixel selection: a transparent pixel has colour bits [3:0] equal to zero.
  always_comb begin
    sel_idx = tile_color;
    if (tile_prio && (|tile_color[3:0]))
      sel_idx = tile_color;
    else if (|obj_color[3:0])
      sel_idx = obj_color;
  end

  // The RAM has a single port. The pixel pipeline owns it on ce_pix clocks,
  // and the CPU owns it otherwise. Because a CPU write never happens on the
  // same clock as a pixel read, the pixel always sees a whole old word or a
  // whole new word, never a mix.
  assign ram_addr = ce_pix ? s1_idx : cpu_addr_q;
  assign ram_we   = !reset && !ce_pix && (state == WAIT) && cpu_wr_q;

  // Palette storage has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (ram_we)
      pal[ram_addr] <= cpu_data_q;
  end

  // Pixel pipeline: S1 registers the selected index, S2 reads the RAM, S3 expands to RGB.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_idx <= '0;
      pix_q  <= '0;
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      hb_d   <= '0;
      vb_d   <= '0;
      hs_d   <= '0;
      vs_d   <= '0;
    end else if (ce_pix) begin
      s1_idx <= sel_idx;
      pix_q  <= pal[ram_addr][14:0];
      if (blank_s3) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= {pix_q[4:0],   pix_q[4:2]};
        green <= {pix_q[9:5],   pix_q[9:7]};
        blue  <= {pix_q[14:10], pix_q[14:12]};
      end
      hb_d <= {hb_d[1:0], hblank_in};
      vb_d <= {vb_d[1:0], vblank_in};
      hs_d <= {hs_d[1:0], hsync_in};
      vs_d <= {vs_d[1:0], vsync_in};
    end
  end

  // Blanking uses the timing bit that moves into the output stage on this
  // same edge, so the black RGB and the delayed blank output appear together.
  assign blank_s3 = (BLANK_BLACK != 0) && (hb_d[1] || vb_d[1]);

  assign hblank = hb_d[2];
  assign vblank = vb_d[2];
  assign hsync  = hs_d[2];
  assign vsync  = vs_d[2];

  // CPU access FSM. Strobes are accepted only in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_dout   <= '0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
      cpu_wr_q   <= 1'b0;
      cpu_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_cs && (cpu_rd || cpu_wr)) begin
            cpu_addr_q <= cpu_addr;
            cpu_data_q <= cpu_din;
            cpu_wr_q   <= cpu_wr;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (!ce_pix) begin
            if (!cpu_wr_q)
              cpu_q <= pal[ram_addr];
            state <= DONE;
          end
        end
        DONE: begin
          if (!cpu_wr_q)
            cpu_dout <= cpu_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
